// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds state encoding, register-index width and the control bundle helpers.
package pipe_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    DIV_WAIT   = 2'd2,
    TRAP_DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic pc_hold;
    logic pc_load;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_hold;
    logic idex_flush;
    logic exmem_hold;
    logic exmem_flush;
    logic memwb_hold;
    logic memwb_flush;
  } ctrl_t;

  // Freeze everything upstream of MEM and bubble MEM/WB while data memory stalls.
  function automatic ctrl_t mem_stall_ctrl();
    ctrl_t c;
    c             = '0;
    c.pc_hold     = 1'b1;
    c.ifid_hold   = 1'b1;
    c.idex_hold   = 1'b1;
    c.exmem_hold  = 1'b1;
    c.memwb_flush = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t div_stall_ctrl();
    ctrl_t c;
    c             = '0;
    c.pc_hold     = 1'b1;
    c.ifid_hold   = 1'b1;
    c.idex_hold   = 1'b1;
    c.exmem_flush = 1'b1;
    return c;
  endfunction

  // A register never sees hold and flush together; flush wins.
  function automatic ctrl_t resolve_ctrl(ctrl_t c_in);
    ctrl_t c;
    c            = c_in;
    c.ifid_hold  = c_in.ifid_hold  & ~c_in.ifid_flush;
    c.idex_hold  = c_in.idex_hold  & ~c_in.idex_flush;
    c.exmem_hold = c_in.exmem_hold & ~c_in.exmem_flush;
    c.memwb_hold = c_in.memwb_hold & ~c_in.memwb_flush;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-source inputs and pipeline-control outputs of the hazard controller.
// master = pipeline side, slave = controller side.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned CntWidth  = 16
);
  import pipe_pkg::*;

  logic [REG_W-1:0]     id_rs1;
  logic [REG_W-1:0]     id_rs2;
  logic                 id_use_rs1;
  logic                 id_use_rs2;
  logic [REG_W-1:0]     ex_rd;
  logic                 ex_is_load;
  logic                 ex_branch_taken;
  logic [DataWidth-1:0] ex_branch_target;
  logic                 ex_div_start;
  logic                 div_done;
  logic                 mem_req;
  logic                 mem_ready;
  logic                 trap_req;
  logic [DataWidth-1:0] trap_vector;
  logic                 stall_clr;

  logic                 pc_hold;
  logic                 pc_load;
  logic [DataWidth-1:0] pc_target;
  logic                 ifid_hold;
  logic                 ifid_flush;
  logic                 idex_hold;
  logic                 idex_flush;
  logic                 exmem_hold;
  logic                 exmem_flush;
  logic                 memwb_hold;
  logic                 memwb_flush;
  logic                 ctrl_busy;
  logic [CntWidth-1:0]  stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_branch_taken, ex_branch_target, ex_div_start, div_done,
           mem_req, mem_ready, trap_req, trap_vector, stall_clr,
    input  pc_hold, pc_load, pc_target, ifid_hold, ifid_flush, idex_hold,
           idex_flush, exmem_hold, exmem_flush, memwb_hold, memwb_flush,
           ctrl_busy, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_branch_taken, ex_branch_target, ex_div_start, div_done,
           mem_req, mem_ready, trap_req, trap_vector, stall_clr,
    output pc_hold, pc_load, pc_target, ifid_hold, ifid_flush, idex_hold,
           idex_flush, exmem_hold, exmem_flush, memwb_hold, memwb_flush,
           ctrl_busy, stall_cnt
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use comparator between the ID sources and the EX load target.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  output logic             load_use
);

  always_comb begin
    load_use = ex_is_load && (ex_rd != REG_X0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard/sequencing controller for the 5-stage pipeline: Mealy flush/hold
// and PC redirect outputs, multi-cycle stall FSM and saturating stall counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_arst,
  pipe_hazard_ctrl_if.slave     hz
);

  state_t               state;
  state_t               state_nxt;
  ctrl_t                ctrl;
  logic [DataWidth-1:0] target;
  logic [CntWidth-1:0]  cnt;
  logic                 load_use;
  logic                 mem_stall;

  hazard_detect u_hazard_detect (
    .id_rs1     (hz.id_rs1),
    .id_rs2     (hz.id_rs2),
    .id_use_rs1 (hz.id_use_rs1),
    .id_use_rs2 (hz.id_use_rs2),
    .ex_rd      (hz.ex_rd),
    .ex_is_load (hz.ex_is_load),
    .load_use   (load_use)
  );

  always_comb begin
    ctrl      = '0;
    target    = '0;
    state_nxt = state;
    mem_stall = hz.mem_req && !hz.mem_ready;

    unique case (state)
      RUN: begin
        if (mem_stall) begin
          ctrl      = mem_stall_ctrl();
          state_nxt = MEM_WAIT;
        end else if (hz.trap_req) begin
          ctrl.pc_load     = 1'b1;
          ctrl.ifid_flush  = 1'b1;
          ctrl.idex_flush  = 1'b1;
          ctrl.exmem_flush = 1'b1;
          target           = hz.trap_vector;
          state_nxt        = TRAP_DRAIN;
        end else if (hz.ex_div_start) begin
          ctrl      = div_stall_ctrl();
          state_nxt = DIV_WAIT;
        end else if (hz.ex_branch_taken) begin
          ctrl.pc_load    = 1'b1;
          ctrl.ifid_flush = 1'b1;
          ctrl.idex_flush = 1'b1;
          target          = hz.ex_branch_target;
        end else if (load_use) begin
          ctrl.pc_hold    = 1'b1;
          ctrl.ifid_hold  = 1'b1;
          ctrl.idex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!hz.mem_ready) ctrl = mem_stall_ctrl();
        else               state_nxt = RUN;
      end
      DIV_WAIT: begin
        // A memory stall here takes over the outputs but keeps waiting on the divider.
        if (mem_stall)         ctrl = mem_stall_ctrl();
        else if (!hz.div_done) ctrl = div_stall_ctrl();
        else                   state_nxt = RUN;
      end
      TRAP_DRAIN: begin
        ctrl.ifid_flush = 1'b1;
        state_nxt       = RUN;
      end
      default: state_nxt = RUN;
    endcase

    ctrl = resolve_ctrl(ctrl);

    if (sys_arst) begin
      ctrl             = '0;
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      ctrl.exmem_flush = 1'b1;
      ctrl.memwb_flush = 1'b1;
    end

    if (!ctrl.pc_load) target = '0;
  end

  always_ff @(posedge sys_clk or posedge sys_arst) begin
    if (sys_arst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (hz.stall_clr)                   cnt <= '0;
      else if (ctrl.pc_hold && cnt != '1) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    hz.pc_hold     = ctrl.pc_hold;
    hz.pc_load     = ctrl.pc_load;
    hz.pc_target   = target;
    hz.ifid_hold   = ctrl.ifid_hold;
    hz.ifid_flush  = ctrl.ifid_flush;
    hz.idex_hold   = ctrl.idex_hold;
    hz.idex_flush  = ctrl.idex_flush;
    hz.exmem_hold  = ctrl.exmem_hold;
    hz.exmem_flush = ctrl.exmem_flush;
    hz.memwb_hold  = ctrl.memwb_hold;
    hz.memwb_flush = ctrl.memwb_flush;
    hz.ctrl_busy   = (state != RUN);
    hz.stall_cnt   = cnt;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (CntWidth = 4 to reach saturation).
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst;
  int unsigned tests;
  int unsigned failed;

  pipe_hazard_ctrl_if #(.DataWidth(32), .CntWidth(4)) hz ();

  pipe_hazard_ctrl #(.DataWidth(32), .CntWidth(4)) dut (
    .sys_clk  (clk),
    .sys_arst (rst),
    .hz       (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
    hz.ex_rd = '0; hz.ex_is_load = 1'b0; hz.ex_branch_taken = 1'b0;
    hz.ex_branch_target = '0; hz.ex_div_start = 1'b0; hz.div_done = 1'b0;
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0; hz.trap_req = 1'b0;
    hz.trap_vector = '0; hz.stall_clr = 1'b0;
  endtask

  task automatic set_load_use();
    hz.ex_is_load = 1'b1; hz.ex_rd = 5'd5; hz.id_rs2 = 5'd5; hz.id_use_rs2 = 1'b1;
  endtask

  function automatic logic [3:0] flushes();
    return {hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.memwb_flush};
  endfunction

  function automatic logic [3:0] holds();
    return {hz.ifid_hold, hz.idex_hold, hz.exmem_hold, hz.memwb_hold};
  endfunction

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    idle();
    #2;
    chk("rst_flush", 32'(flushes()), 32'hF);
    chk("rst_hold", 32'(holds()), 32'h0);
    chk("rst_pc", 32'({hz.pc_hold, hz.pc_load}), 32'h0);
    chk("rst_tgt", hz.pc_target, 32'h0);
    chk("rst_busy", 32'(hz.ctrl_busy), 32'h0);
    chk("rst_cnt", 32'(hz.stall_cnt), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("run_idle_flush", 32'(flushes()), 32'h0);

    // load-use via rs2
    set_load_use();
    #1;
    chk("lu_pc_hold", 32'(hz.pc_hold), 32'h1);
    chk("lu_holds", 32'(holds()), 32'b1000);
    chk("lu_flushes", 32'(flushes()), 32'b0100);
    tick();
    idle();
    chk("lu_cnt", 32'(hz.stall_cnt), 32'h1);
    // x0 destination never stalls
    hz.ex_is_load = 1'b1; hz.ex_rd = 5'd0; hz.id_rs2 = 5'd0; hz.id_use_rs2 = 1'b1;
    #1;
    chk("lu_x0_hold", 32'(hz.pc_hold), 32'h0);
    chk("lu_x0_flush", 32'(flushes()), 32'h0);
    // rs1 match but rs1 not used
    idle();
    hz.ex_is_load = 1'b1; hz.ex_rd = 5'd7; hz.id_rs1 = 5'd7;
    #1;
    chk("lu_nouse_hold", 32'(hz.pc_hold), 32'h0);
    hz.id_use_rs1 = 1'b1;
    #1;
    chk("lu_rs1_hold", 32'(hz.pc_hold), 32'h1);
    hz.ex_is_load = 1'b0;
    #1;
    chk("lu_notload_hold", 32'(hz.pc_hold), 32'h0);
    tick();
    chk("lu_cnt_kept", 32'(hz.stall_cnt), 32'h1);

    // branch beats load-use
    idle();
    set_load_use();
    hz.ex_branch_taken = 1'b1; hz.ex_branch_target = 32'h0000_0100;
    #1;
    chk("br_pc_load", 32'(hz.pc_load), 32'h1);
    chk("br_tgt", hz.pc_target, 32'h100);
    chk("br_flushes", 32'(flushes()), 32'b1100);
    chk("br_pc_hold", 32'(hz.pc_hold), 32'h0);
    hz.ex_branch_taken = 1'b0;
    idle();
    hz.ex_branch_target = 32'h0000_0100;
    #1;
    chk("br_tgt_zero", hz.pc_target, 32'h0);
    tick();
    chk("br_cnt", 32'(hz.stall_cnt), 32'h1);

    // divide: 4 held cycles, done on the 5th
    hz.stall_clr = 1'b1;
    tick();
    idle();
    chk("clr_cnt", 32'(hz.stall_cnt), 32'h0);
    hz.ex_div_start = 1'b1;
    #1;
    chk("div0_hold", 32'(hz.pc_hold), 32'h1);
    chk("div0_flush", 32'(flushes()), 32'b0010);
    chk("div0_busy", 32'(hz.ctrl_busy), 32'h0);
    tick();
    hz.ex_div_start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      #1;
      chk("divw_busy", 32'(hz.ctrl_busy), 32'h1);
      chk("divw_hold", 32'({hz.pc_hold, holds()}), 32'b11100);
      chk("divw_flush", 32'(flushes()), 32'b0010);
      tick();
    end
    hz.div_done = 1'b1;
    #1;
    chk("divd_hold", 32'(hz.pc_hold), 32'h0);
    chk("divd_flush", 32'(flushes()), 32'h0);
    tick();
    idle();
    chk("divd_busy", 32'(hz.ctrl_busy), 32'h0);
    chk("div_cnt", 32'(hz.stall_cnt), 32'h4);

    // memory wait with trap pending
    hz.stall_clr = 1'b1;
    tick();
    idle();
    hz.mem_req = 1'b1; hz.trap_req = 1'b1; hz.trap_vector = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_memwb_flush", 32'(flushes()), 32'b0001);
      chk("mw_holds", 32'({hz.pc_hold, holds()}), 32'b11110);
      chk("mw_pc_load", 32'(hz.pc_load), 32'h0);
      chk("mw_busy", 32'(hz.ctrl_busy), (i == 0) ? 32'h0 : 32'h1);
      tick();
    end
    hz.mem_ready = 1'b1;
    #1;
    chk("mw_done_pc", 32'({hz.pc_hold, hz.pc_load}), 32'h0);
    chk("mw_done_flush", 32'(flushes()), 32'h0);
    tick();
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
    #1;
    chk("trap_busy", 32'(hz.ctrl_busy), 32'h0);
    chk("trap_pc_load", 32'(hz.pc_load), 32'h1);
    chk("trap_tgt", hz.pc_target, 32'h8000_0000);
    chk("trap_flushes", 32'(flushes()), 32'b1110);
    tick();
    #1;
    chk("drain_busy", 32'(hz.ctrl_busy), 32'h1);
    chk("drain_flushes", 32'(flushes()), 32'b1000);
    chk("drain_pc_load", 32'(hz.pc_load), 32'h0);
    tick();
    idle();
    chk("drain_exit", 32'(hz.ctrl_busy), 32'h0);
    chk("mw_cnt", 32'(hz.stall_cnt), 32'h3);

    // saturation then clear-with-stall
    hz.stall_clr = 1'b1;
    tick();
    idle();
    set_load_use();
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt", 32'(hz.stall_cnt), 32'hF);
    hz.stall_clr = 1'b1;
    #1;
    chk("sat_clr_hold", 32'(hz.pc_hold), 32'h1);
    tick();
    chk("sat_clr_cnt", 32'(hz.stall_cnt), 32'h0);
    idle();
    tick();
    chk("sat_idle_cnt", 32'(hz.stall_cnt), 32'h0);

    // reset while waiting on the divider
    hz.ex_div_start = 1'b1;
    tick();
    hz.ex_div_start = 1'b0;
    tick();
    chk("rdiv_busy", 32'(hz.ctrl_busy), 32'h1);
    hz.mem_req = 1'b1;
    #1;
    chk("rdiv_mem_flush", 32'(flushes()), 32'b0001);
    chk("rdiv_mem_busy", 32'(hz.ctrl_busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("rdiv_rst_flush", 32'(flushes()), 32'hF);
    chk("rdiv_rst_busy", 32'(hz.ctrl_busy), 32'h0);
    chk("rdiv_rst_cnt", 32'(hz.stall_cnt), 32'h0);
    chk("rdiv_rst_pc", 32'({hz.pc_hold, hz.pc_load}), 32'h0);
    idle();
    tick();
    rst = 1'b0;
    tick();
    chk("rdiv_after_busy", 32'(hz.ctrl_busy), 32'h0);
    chk("rdiv_after_hold", 32'(hz.pc_hold), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
